gpout_bank: RTL and testbench



---
 rtl/gpout_pkg.sv | 15 +
 rtl/gpout_bank_if.sv | 22 ++
 rtl/gpout_chan.sv | 84 ++++++++
 rtl/gpout_bank.sv | 49 ++++
 tb/tb_gpout_bank.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpout_pkg.sv
// Shared constants for the gpout debug output bank.
package gpout_pkg;
  // Per-channel conditioning modes
  localparam logic [1:0] GP_RAW     = 2'd0;
  localparam logic [1:0] GP_SYNC    = 2'd1;
  localparam logic [1:0] GP_STRETCH = 2'd2;
  localparam logic [1:0] GP_TOGGLE  = 2'd3;

  // Default build parameters
  localparam int GP_NCH    = 6;
  localparam int GP_NSRC   = 64;
  localparam int GP_SEL_W  = 6;
  localparam int GP_STR_W  = 8;
  localparam int GP_DIV_CW = 16;
endpackage

// File: rtl/gpout_bank_if.sv
// Select/mode/source bus and conditioned outputs of the gpout bank.
interface gpout_bank_if
  import gpout_pkg::*;
#(
  parameter int NCH   = GP_NCH,
  parameter int NSRC  = GP_NSRC,
  parameter int SEL_W = GP_SEL_W,
  parameter int STR_W = GP_STR_W
);
  logic [NSRC-1:0]      i_src;
  logic [NCH*SEL_W-1:0] i_sel;
  logic [NCH*2-1:0]     i_mode;
  logic [STR_W-1:0]     i_stretch;
  logic [3:0]           i_div;
  logic [NCH-1:0]       o_gpout;
  logic                 o_clk_div;

  modport master (output i_src, i_sel, i_mode, i_stretch, i_div,
                  input  o_gpout, o_clk_div);
  modport slave  (input  i_src, i_sel, i_mode, i_stretch, i_div,
                  output o_gpout, o_clk_div);
endinterface

// File: rtl/gpout_chan.sv
// One gpout channel: source select, sync chain, edge detect,
// pulse stretcher, edge toggle and clear-on-reconfiguration.
module gpout_chan
  import gpout_pkg::*;
#(
  parameter int NSRC  = GP_NSRC,
  parameter int SEL_W = GP_SEL_W,
  parameter int STR_W = GP_STR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  src,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic [STR_W-1:0] stretch,
  output logic             gpout
);
  // Source bus padded to the full select range; out-of-range selects read 0
  logic [2**SEL_W-1:0] src_ext;
  logic                s;

  logic                q1, q2, q3;
  logic                start;
  logic [STR_W-1:0]    cnt;
  logic                tog;
  logic [SEL_W+1:0]    cfg_q;
  logic                cfg_chg;
  logic                rise;

  // Zero-extend the source bus so any select value indexes safely
  always_comb begin
    src_ext = '0;
    src_ext[NSRC-1:0] = src;
  end

  assign s       = src_ext[sel];
  assign cfg_chg = ({sel, mode} != cfg_q);
  assign rise    = q2 & ~q3;

  // Sync chain, stretcher and toggle; a config change wipes all history
  always_ff @(posedge clk) begin
    if (reset) begin
      q1    <= 1'b0;
      q2    <= 1'b0;
      q3    <= 1'b0;
      start <= 1'b0;
      cnt   <= '0;
      tog   <= 1'b0;
      cfg_q <= '0;
    end else if (cfg_chg) begin
      q1    <= 1'b0;
      q2    <= 1'b0;
      q3    <= 1'b0;
      start <= 1'b0;
      cnt   <= '0;
      tog   <= 1'b0;
      cfg_q <= {sel, mode};
    end else begin
      q1  <= s;
      q2  <= q1;
      q3  <= q2;
      tog <= tog ^ rise;
      if (rise) begin
        // start flag covers the first cycle, cnt the remaining 'stretch'
        start <= 1'b1;
        cnt   <= stretch;
      end else begin
        start <= 1'b0;
        if (!start && cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  // Output select; RAW bypasses all flops so reset/clock stay observable
  always_comb begin
    gpout = s;
    case (mode)
      GP_RAW:     gpout = s;
      GP_SYNC:    gpout = q2;
      GP_STRETCH: gpout = start | (cnt != '0);
      GP_TOGGLE:  gpout = tog;
    endcase
  end
endmodule

// File: rtl/gpout_bank.sv
// NCH-channel debug output mux with per-channel conditioning and a
// power-of-two clock divider output.
module gpout_bank
  import gpout_pkg::*;
#(
  parameter int NCH    = GP_NCH,
  parameter int NSRC   = GP_NSRC,
  parameter int SEL_W  = GP_SEL_W,
  parameter int STR_W  = GP_STR_W,
  parameter int DIV_CW = GP_DIV_CW
) (
  input  logic         clk,
  input  logic         reset,
  gpout_bank_if.slave  bus
);
  logic [NCH-1:0]    gp;
  logic [DIV_CW-1:0] ctr;
  logic              clk_div;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    gpout_chan #(
      .NSRC  (NSRC),
      .SEL_W (SEL_W),
      .STR_W (STR_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .src     (bus.i_src),
      .sel     (bus.i_sel[c*SEL_W +: SEL_W]),
      .mode    (bus.i_mode[c*2 +: 2]),
      .stretch (bus.i_stretch),
      .gpout   (gp[c])
    );
  end

  // Free-running counter; the selected tap is registered for a clean edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr     <= '0;
      clk_div <= 1'b0;
    end else begin
      ctr     <= ctr + 1'b1;
      clk_div <= ctr[bus.i_div];
    end
  end

  assign bus.o_gpout   = gp;
  assign bus.o_clk_div = clk_div;
endmodule

// File: tb/tb_gpout_bank.sv
// Directed bench for gpout_bank: raw, sync, stretch, toggle, out-of-range
// select and clock divider.
module tb_gpout_bank;
  import gpout_pkg::*;

  localparam int NCH    = 6;
  localparam int NSRC   = 64;
  localparam int SEL_W  = 7;   // wide enough to express selects >= NSRC
  localparam int STR_W  = 8;
  localparam int DIV_CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gpout_bank_if #(.NCH(NCH), .NSRC(NSRC), .SEL_W(SEL_W), .STR_W(STR_W)) bus ();

  gpout_bank #(
    .NCH(NCH), .NSRC(NSRC), .SEL_W(SEL_W), .STR_W(STR_W), .DIV_CW(DIV_CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int c, input int sel, input logic [1:0] m);
    bus.i_sel[c*SEL_W +: SEL_W] = SEL_W'(sel);
    bus.i_mode[c*2 +: 2]        = m;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.i_src     = '0;
    bus.i_sel     = '0;
    bus.i_mode    = '0;
    bus.i_stretch = 8'd4;
    bus.i_div     = 4'd0;
    set_cfg(0, 5,  GP_RAW);
    set_cfg(1, 10, GP_SYNC);
    set_cfg(2, 20, GP_STRETCH);
    set_cfg(3, 30, GP_TOGGLE);
    set_cfg(4, 70, GP_SYNC);
    set_cfg(5, 0,  GP_RAW);
    tick(); tick();
    n_cmp++;
    if (bus.o_gpout !== 6'b000000) begin
      n_bad++; $display("FAIL reset_gpout: got %b want 000000", bus.o_gpout);
    end
    n_cmp++;
    if (bus.o_clk_div !== 1'b0) begin
      n_bad++; $display("FAIL reset_clkdiv: got %b want 0", bus.o_clk_div);
    end
  endtask

  // Reset is still held here: RAW must follow, SYNC must stay 0
  task automatic test_raw();
    bus.i_src[5] = 1'b1; #1;
    n_cmp++;
    if (bus.o_gpout[0] !== 1'b1) begin
      n_bad++; $display("FAIL raw_rise: got %b want 1", bus.o_gpout[0]);
    end
    bus.i_src[5] = 1'b0; #1;
    n_cmp++;
    if (bus.o_gpout[0] !== 1'b0) begin
      n_bad++; $display("FAIL raw_fall: got %b want 0", bus.o_gpout[0]);
    end
    bus.i_src[10] = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.o_gpout[1] !== 1'b0) begin
      n_bad++; $display("FAIL sync_in_reset: got %b want 0", bus.o_gpout[1]);
    end
    bus.i_src[10] = 1'b0;
    reset = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_sync();
    logic exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.i_src[10] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) bus.i_src[10] = 1'b0;
      tick();
      n_cmp++;
      if (bus.o_gpout[1] !== exp[k]) begin
        n_bad++;
        $display("FAIL sync_edge%0d: got %b want %b", k, bus.o_gpout[1], exp[k]);
      end
    end
  endtask

  // Scenarios: stretch 4 single pulse, stretch 4 retriggered, stretch 0
  task automatic test_stretch();
    int st   [3] = '{4, 4, 0};
    int e_n  [3] = '{5, 8, 1};
    int e_lo [3] = '{2, 2, 2};
    int e_hi [3] = '{6, 9, 2};
    for (int sc = 0; sc < 3; sc++) begin
      int n = 0, lo = -1, hi = -1;
      bus.i_stretch = STR_W'(st[sc]);
      bus.i_src[20] = 1'b1;
      tick();
      bus.i_src[20] = 1'b0;
      for (int j = 0; j < 16; j++) begin
        if (j > 0) tick();
        if (bus.o_gpout[2] === 1'b1) begin
          n++;
          if (lo < 0) lo = j;
          hi = j;
        end
        if (sc == 1 && j == 2) bus.i_src[20] = 1'b1;
        if (sc == 1 && j == 3) bus.i_src[20] = 1'b0;
      end
      n_cmp++;
      if (n !== e_n[sc]) begin
        n_bad++; $display("FAIL stretch%0d_len: got %0d want %0d", sc, n, e_n[sc]);
      end
      n_cmp++;
      if (lo !== e_lo[sc] || hi !== e_hi[sc]) begin
        n_bad++;
        $display("FAIL stretch%0d_span: got %0d..%0d want %0d..%0d",
                 sc, lo, hi, e_lo[sc], e_hi[sc]);
      end
    end
  endtask

  task automatic test_toggle();
    for (int p = 0; p < 3; p++) begin
      bus.i_src[30] = 1'b1;
      tick();
      bus.i_src[30] = 1'b0;
      tick(); tick(); tick(); tick();
      n_cmp++;
      if (bus.o_gpout[3] !== ((p % 2) == 0)) begin
        n_bad++;
        $display("FAIL toggle%0d: got %b want %b", p, bus.o_gpout[3], (p % 2) == 0);
      end
    end
    set_cfg(3, 31, GP_TOGGLE);
    tick();
    n_cmp++;
    if (bus.o_gpout[3] !== 1'b0) begin
      n_bad++; $display("FAIL toggle_reconfig: got %b want 0", bus.o_gpout[3]);
    end
    tick(); tick();
    n_cmp++;
    if (bus.o_gpout[3] !== 1'b0) begin
      n_bad++; $display("FAIL toggle_hold0: got %b want 0", bus.o_gpout[3]);
    end
    bus.i_src[31] = 1'b1;
    tick();
    bus.i_src[31] = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.o_gpout[3] !== 1'b1) begin
      n_bad++; $display("FAIL toggle_resume: got %b want 1", bus.o_gpout[3]);
    end
  endtask

  task automatic test_out_of_range();
    bus.i_src = '1;
    for (int m = 0; m < 4; m++) begin
      set_cfg(4, 70, 2'(m));
      #1;
      n_cmp++;
      if (bus.o_gpout[4] !== 1'b0) begin
        n_bad++; $display("FAIL oor_mode%0d_now: got %b want 0", m, bus.o_gpout[4]);
      end
      tick(); tick(); tick(); tick();
      n_cmp++;
      if (bus.o_gpout[4] !== 1'b0) begin
        n_bad++; $display("FAIL oor_mode%0d_late: got %b want 0", m, bus.o_gpout[4]);
      end
    end
    bus.i_src = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_divider();
    // i_div=0: toggles every cycle after reset release
    bus.i_div = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (bus.o_clk_div !== 1'((k - 1) & 1)) begin
        n_bad++;
        $display("FAIL div0_k%0d: got %b want %0d", k, bus.o_clk_div, (k - 1) & 1);
      end
    end
    // i_div=3: run into a high phase, then reset mid-count
    bus.i_div = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    n_cmp++;
    if (bus.o_clk_div !== 1'b1) begin
      n_bad++; $display("FAIL div3_precount: got %b want 1", bus.o_clk_div);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_clk_div !== 1'b0) begin
      n_bad++; $display("FAIL div3_midreset: got %b want 0", bus.o_clk_div);
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_cmp++;
      if (bus.o_clk_div !== 1'(((k - 1) >> 3) & 1)) begin
        n_bad++;
        $display("FAIL div3_k%0d: got %b want %0d", k, bus.o_clk_div, ((k - 1) >> 3) & 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_sync();
    test_stretch();
    test_toggle();
    test_out_of_range();
    test_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
